// File: rtl/mole_game_if.sv
// Whack-a-mole control bundle: input pulses in, mole/score/lives state out.
// master drives start/eval_now/user_guess; slave is the round sequencer.
interface mole_game_if #(
    parameter int unsigned SCORE_W = 8
);
    logic               start;
    logic               eval_now;
    logic [2:0]         user_guess;
    logic [2:0]         mole_pos;
    logic               mole_valid;
    logic [SCORE_W-1:0] score;
    logic [2:0]         lives;
    logic               hit_pulse;
    logic               miss_pulse;
    logic               game_over;

    modport master (
        output start, eval_now, user_guess,
        input  mole_pos, mole_valid, score, lives,
        input  hit_pulse, miss_pulse, game_over
    );

    modport slave (
        input  start, eval_now, user_guess,
        output mole_pos, mole_valid, score, lives,
        output hit_pulse, miss_pulse, game_over
    );
endinterface

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole round sequencer: LFSR spawn, timed window, score and lives.
// Optional MOLE_SPEEDUP_EN: each hit shortens the round window.
module mole_game_ctrl #(
    parameter int unsigned ROUND_CYCLES    = 100_000_000,
    parameter int unsigned FEEDBACK_CYCLES = 25_000_000,
    parameter int unsigned LIVES           = 3,
    parameter int unsigned SCORE_W         = 8,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input logic        clk,
    input logic        rst,
    mole_game_if.slave gif
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SPAWN = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HIT   = 3'd3;
    localparam logic [2:0] S_MISS  = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;

    localparam int unsigned TMAX =
        (ROUND_CYCLES > FEEDBACK_CYCLES) ? ROUND_CYCLES : FEEDBACK_CYCLES;
    localparam int unsigned TW = $clog2(TMAX);
    localparam int unsigned RW = $clog2(ROUND_CYCLES + 1);

    localparam logic [2:0]    NO_MOLE = 3'd5;
    localparam logic [2:0]    LIVES_I = 3'(LIVES);
    localparam logic [TW-1:0] FB_LOAD = TW'(FEEDBACK_CYCLES - 1);

    logic [2:0]         state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [2:0]         pos_q, pos_d;
    logic [2:0]         prev_q, prev_d;
    logic               valid_q, valid_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         lives_q, lives_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               over_q, over_d;

    logic          game_start;
    logic          guess_ok;
    logic          hit_ev;
    logic          miss_ev;
    logic [2:0]    r;
    logic [2:0]    cand0;
    logic [2:0]    cand;
    logic [2:0]    lives_dec;
    logic [RW-1:0] round_len;

    assign game_start = gif.start &&
                        (state_q == S_IDLE || state_q == S_OVER);
    assign guess_ok   = (gif.user_guess == pos_q);
    assign hit_ev     = (state_q == S_WAIT) && gif.eval_now && guess_ok;
    // A guess on the last window cycle is judged rather than timed out.
    assign miss_ev    = (state_q == S_WAIT) &&
                        (gif.eval_now ? !guess_ok : (timer_q == '0));
    assign lives_dec  = lives_q - 3'd1;

    assign r     = lfsr_q[2:0];
    assign cand0 = (r >= 3'd5) ? (r - 3'd5) : r;
    assign cand  = (cand0 != prev_q) ? cand0 :
                   (cand0 == 3'd4)   ? 3'd0  : (cand0 + 3'd1);

    assign lfsr_d = {lfsr_q[14:0],
                     lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

`ifdef MOLE_SPEEDUP_EN
    localparam logic [RW-1:0] RL_INIT = RW'(ROUND_CYCLES);
    localparam logic [RW-1:0] RL_STEP = RW'(ROUND_CYCLES >> 4);
    localparam logic [RW-1:0] RL_MIN  = RW'(ROUND_CYCLES >> 2);

    logic [RW-1:0] round_len_q, round_len_d;

    always_comb begin
        round_len_d = round_len_q;
        if (game_start) begin
            round_len_d = RL_INIT;
        end else if (hit_ev) begin
            round_len_d = (round_len_q >= RL_MIN + RL_STEP) ?
                          (round_len_q - RL_STEP) : RL_MIN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            round_len_q <= RL_INIT;
        end else begin
            round_len_q <= round_len_d;
        end
    end

    assign round_len = round_len_q;
`else
    assign round_len = RW'(ROUND_CYCLES);
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pos_d   = pos_q;
        prev_d  = prev_q;
        valid_d = valid_q;
        score_d = score_q;
        lives_d = lives_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        over_d  = over_q;
        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (game_start) begin
                    state_d = S_SPAWN;
                    score_d = '0;
                    lives_d = LIVES_I;
                    over_d  = 1'b0;
                    prev_d  = NO_MOLE;
                end
            end
            S_SPAWN: begin
                state_d = S_WAIT;
                pos_d   = cand;
                prev_d  = cand;
                valid_d = 1'b1;
                timer_d = TW'(round_len - RW'(1));
            end
            S_WAIT: begin
                timer_d = timer_q - TW'(1);
                if (hit_ev) begin
                    state_d = S_HIT;
                    hit_d   = 1'b1;
                    score_d = (&score_q) ? score_q : (score_q + 1'b1);
                    valid_d = 1'b0;
                    pos_d   = NO_MOLE;
                    timer_d = FB_LOAD;
                end else if (miss_ev) begin
                    miss_d  = 1'b1;
                    lives_d = lives_dec;
                    valid_d = 1'b0;
                    pos_d   = NO_MOLE;
                    timer_d = FB_LOAD;
                    if (lives_dec == 3'd0) begin
                        state_d = S_OVER;
                        over_d  = 1'b1;
                    end else begin
                        state_d = S_MISS;
                    end
                end
            end
            S_HIT, S_MISS: begin
                if (timer_q == '0) begin
                    state_d = S_SPAWN;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            timer_q <= '0;
            pos_q   <= NO_MOLE;
            prev_q  <= NO_MOLE;
            valid_q <= 1'b0;
            score_q <= '0;
            lives_q <= LIVES_I;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            timer_q <= timer_d;
            pos_q   <= pos_d;
            prev_q  <= prev_d;
            valid_q <= valid_d;
            score_q <= score_d;
            lives_q <= lives_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            over_q  <= over_d;
        end
    end

    assign gif.mole_pos   = pos_q;
    assign gif.mole_valid = valid_q;
    assign gif.score      = score_q;
    assign gif.lives      = lives_q;
    assign gif.hit_pulse  = hit_q;
    assign gif.miss_pulse = miss_q;
    assign gif.game_over  = over_q;
endmodule
